// File: rtl/tx_resp_arbiter_pkg.sv
// ============================================================================
// tx_resp_arbiter_pkg : shared state encoding and grant IDs for the arbiter
// Revision: 1.0
// ============================================================================
`default_nettype none

package tx_resp_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE        = 2'b00,
        SEND_RD     = 2'b01,
        SEND_ALU_LO = 2'b10,
        SEND_ALU_HI = 2'b11
    } state_t;

    localparam logic GNT_RD  = 1'b0;
    localparam logic GNT_ALU = 1'b1;

endpackage

`default_nettype wire

// File: rtl/tx_resp_arbiter_if.sv
// ============================================================================
// tx_resp_arbiter_if : response inputs, FIFO write side and status outputs
// Revision: 1.0
// ============================================================================
`default_nettype none

interface tx_resp_arbiter_if
    import tx_resp_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
);
    logic [DATA_WIDTH-1:0] RD_DATA;
    logic                  RD_DATA_VLD;
    logic [ALU_WIDTH-1:0]  ALU_OUT;
    logic                  ALU_OUT_VLD;
    logic                  FIFO_FULL;
    logic [DATA_WIDTH-1:0] WR_DATA;
    logic                  W_INC;
    logic                  RD_BUSY;
    logic                  ALU_BUSY;
    logic                  OVF;

    modport slave (
        input  RD_DATA, RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        output WR_DATA, W_INC, RD_BUSY, ALU_BUSY, OVF
    );

    modport master (
        output RD_DATA, RD_DATA_VLD, ALU_OUT, ALU_OUT_VLD, FIFO_FULL,
        input  WR_DATA, W_INC, RD_BUSY, ALU_BUSY, OVF
    );
endinterface

`default_nettype wire

// File: rtl/tx_resp_arbiter_resp_slot.sv
// ============================================================================
// resp_slot : one-deep response holding register with pend flag and drop detect
// Revision: 1.0
// ============================================================================
`default_nettype none

module resp_slot
    import tx_resp_arbiter_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  wire logic             CLK,
    input  wire logic             RST,
    input  wire logic             vld_i,
    input  wire logic [WIDTH-1:0] data_i,
    input  wire logic             clr_i,
    output logic      [WIDTH-1:0] data_o,
    output logic                  pend_o,
    output logic                  drop_o
);
    logic [WIDTH-1:0] data_q;
    logic             pend_q;
    logic             w_free;

    // A slot being emptied by its final handshake on this edge can accept a new response.
    assign w_free = !pend_q || clr_i;
    assign drop_o = vld_i && !w_free;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            data_q <= '0;
            pend_q <= 1'b0;
        end else if (vld_i && w_free) begin
            data_q <= data_i;
            pend_q <= 1'b1;
        end else if (clr_i) begin
            pend_q <= 1'b0;
        end
    end

    assign data_o = data_q;
    assign pend_o = pend_q;
endmodule

`default_nettype wire

// File: rtl/tx_resp_arbiter.sv
// ============================================================================
// tx_resp_arbiter : round-robin scheduler of RegFile/ALU responses onto FIFO write
// Revision: 1.0
// ============================================================================
`default_nettype none

module tx_resp_arbiter
    import tx_resp_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ALU_WIDTH  = 16
) (
    input  wire logic           CLK,
    input  wire logic           RST,
    tx_resp_arbiter_if.slave    bus
);
    logic [DATA_WIDTH-1:0] rd_data;
    logic [ALU_WIDTH-1:0]  alu_data;
    logic                  rd_pend, alu_pend;
    logic                  rd_drop, alu_drop;
    logic                  rd_clr, alu_clr;

    state_t                state_q, state_d;
    logic                  last_grant_q, last_grant_d;
    logic [DATA_WIDTH-1:0] wr_hold_q;
    logic [DATA_WIDTH-1:0] w_byte;
    logic                  w_inc;
    logic                  ovf_q;

    resp_slot #(.WIDTH(DATA_WIDTH)) u_rd_slot (
        .CLK    (CLK),
        .RST    (RST),
        .vld_i  (bus.RD_DATA_VLD),
        .data_i (bus.RD_DATA),
        .clr_i  (rd_clr),
        .data_o (rd_data),
        .pend_o (rd_pend),
        .drop_o (rd_drop)
    );

    resp_slot #(.WIDTH(ALU_WIDTH)) u_alu_slot (
        .CLK    (CLK),
        .RST    (RST),
        .vld_i  (bus.ALU_OUT_VLD),
        .data_i (bus.ALU_OUT),
        .clr_i  (alu_clr),
        .data_o (alu_data),
        .pend_o (alu_pend),
        .drop_o (alu_drop)
    );

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q      <= IDLE;
            last_grant_q <= GNT_ALU;
            wr_hold_q    <= '0;
            ovf_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            wr_hold_q    <= w_byte;
            ovf_q        <= rd_drop || alu_drop;
        end
    end

    // Once SEND_ALU_LO is entered the FSM only returns to IDLE after the MSB,
    // so an ALU frame can never be split by an RD byte.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        rd_clr       = 1'b0;
        alu_clr      = 1'b0;
        w_inc        = 1'b0;
        w_byte       = wr_hold_q;
        case (state_q)
            IDLE: begin
                if (rd_pend && (!alu_pend || last_grant_q == GNT_ALU)) begin
                    state_d      = SEND_RD;
                    last_grant_d = GNT_RD;
                end else if (alu_pend) begin
                    state_d      = SEND_ALU_LO;
                    last_grant_d = GNT_ALU;
                end
            end
            SEND_RD: begin
                w_byte = rd_data;
                w_inc  = !bus.FIFO_FULL;
                if (!bus.FIFO_FULL) begin
                    rd_clr  = 1'b1;
                    state_d = IDLE;
                end
            end
            SEND_ALU_LO: begin
                w_byte = alu_data[DATA_WIDTH-1:0];
                w_inc  = !bus.FIFO_FULL;
                if (!bus.FIFO_FULL) begin
                    state_d = SEND_ALU_HI;
                end
            end
            SEND_ALU_HI: begin
                w_byte = alu_data[ALU_WIDTH-1:DATA_WIDTH];
                w_inc  = !bus.FIFO_FULL;
                if (!bus.FIFO_FULL) begin
                    alu_clr = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.WR_DATA  = w_byte;
    assign bus.W_INC    = w_inc;
    assign bus.RD_BUSY  = rd_pend;
    assign bus.ALU_BUSY = alu_pend;
    assign bus.OVF      = ovf_q;
endmodule

`default_nettype wire
